// File: rtl/rf_pkg.sv
// Shared types and default sizes for the rf_drsw register-file bank.
package rf_pkg;

    localparam int RF_ADDR_W_E = 4;
    localparam int RF_DATA_W   = 32;

    typedef enum logic {RF_INIT, RF_RUN} rf_state_e;

    typedef logic [RF_ADDR_W_E-1:0] rf_addr_t;
    typedef logic [RF_DATA_W-1:0]   rf_data_t;

endpackage

// File: rtl/rf_init_seq.sv
// Post-reset clear sequencer: walks entries 1..N_REGS-1 one per cycle,
// then flags InitDone and hands the array over to the core.
module rf_init_seq
    import rf_pkg::*;
#(
    parameter int addr_w = RF_ADDR_W_E
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              clr_we,
    output logic [addr_w-1:0] clr_addr,
    output logic              InitDone
);

    // Last physical entry is all-ones; the sweep stops there so the counter never wraps.
    localparam logic [addr_w-1:0] LAST_ADDR  = '1;
    localparam logic [addr_w-1:0] FIRST_ADDR = addr_w'(1);

    rf_state_e         state_q, state_d;
    logic [addr_w-1:0] cnt_q, cnt_d;
    logic              init_done_q, init_done_d;

    // Next-state: clear one entry per cycle while sweeping, then park in RF_RUN.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        init_done_d = init_done_q;
        clr_we      = 1'b0;
        case (state_q)
            RF_INIT: begin
                clr_we = 1'b1;
                if (cnt_q == LAST_ADDR) begin
                    state_d     = RF_RUN;
                    init_done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + addr_w'(1);
                end
            end
            RF_RUN: begin
                state_d = RF_RUN;
            end
            default: begin
                state_d = RF_INIT;
            end
        endcase
    end

    // Sequencer state; any reset restarts the sweep at entry 1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RF_INIT;
            cnt_q       <= FIRST_ADDR;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_done_q <= init_done_d;
        end
    end

    assign clr_addr = cnt_q;
    assign InitDone = init_done_q;

endmodule

// File: rtl/rf_drsw_bank.sv
// Two-read / one-write register file with registered reads and x0 hardwired
// to zero. Storage has no reset; rf_init_seq clears it after every reset.
// Optional macro RF_BYPASS_EN: when defined, a same-cycle write to the address
// being read is forwarded (write-first); otherwise the old value is returned.
module rf_drsw_bank
    import rf_pkg::*;
#(
    parameter int addr_w = RF_ADDR_W_E,
    parameter int data_w = RF_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [addr_w-1:0] RdAddr,
    input  logic [data_w-1:0] RdData,
    input  logic [addr_w-1:0] Rs1Addr,
    input  logic [addr_w-1:0] Rs2Addr,
    output logic [data_w-1:0] Rs1Data,
    output logic [data_w-1:0] Rs2Data,
    output logic              InitDone
);

    localparam int N_REGS = 2 ** addr_w;

    // No entry for x0: reads of address 0 are forced to zero below.
    logic [data_w-1:0] mem [1:N_REGS-1];

    logic              clr_we;
    logic [addr_w-1:0] clr_addr;
    logic              init_done;

    logic              wr_en;
    logic [addr_w-1:0] wr_addr;
    logic [data_w-1:0] wr_data;

    logic [1:0][addr_w-1:0] rs_addr;

    rf_init_seq #(
        .addr_w (addr_w)
    ) u_init_seq (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_we   (clr_we),
        .clr_addr (clr_addr),
        .InitDone (init_done)
    );

    // Write-port mux: the clear sweep owns the port until it finishes.
    always_comb begin
        wr_en   = 1'b0;
        wr_addr = RdAddr;
        wr_data = RdData;
        if (clr_we) begin
            wr_en   = 1'b1;
            wr_addr = clr_addr;
            wr_data = '0;
        end else if (RdAddr != '0) begin
            wr_en = 1'b1;
        end
    end

    // Storage write; wr_addr is never 0 when wr_en is high.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rs_addr[0] = Rs1Addr;
    assign rs_addr[1] = Rs2Addr;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic [data_w-1:0] rs_d;
            logic [data_w-1:0] rs_q;

            // Read-data select: zero during the sweep and for x0.
            always_comb begin
                rs_d = '0;
                if (init_done && (rs_addr[gi] != '0)) begin
                    rs_d = mem[rs_addr[gi]];
`ifdef RF_BYPASS_EN
                    if (rs_addr[gi] == RdAddr) begin
                        rs_d = RdData;
                    end
`endif
                end
            end

            // Registered read data, cleared asynchronously on reset.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rs_q <= '0;
                end else begin
                    rs_q <= rs_d;
                end
            end
        end
    endgenerate

    assign Rs1Data  = g_rd[0].rs_q;
    assign Rs2Data  = g_rd[1].rs_q;
    assign InitDone = init_done;

endmodule

// File: doc/rf_drsw_bank.md
Name: rf_drsw_bank

Overview:
Register-file storage that sits on the regfile end (from_rf modport) of rf_drsw_intf. It provides two read ports and one write port for the core's decode/writeback stages.
- Storage is RAM-inferable: reads are registered and the array has no reset.
- A post-reset sweep clears the array one entry per cycle.
- x0 is hardwired to zero.

Parameters:
- addr_w, 4, register address width (4 = RV32E, 16 architectural regs).
- data_w, 32, register data width.
- Derived constant N_REGS = 2**addr_w. Physical entries 1..N_REGS-1 only; no storage for x0.

Ports:
- clk  input  1  clock; all state on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- rf.RdAddr  input  addr_w  write address via from_rf modport; 0 = no write.
- rf.RdData  input  data_w  write data.
- rf.Rs1Addr  input  addr_w  read port 1 address.
- rf.Rs2Addr  input  addr_w  read port 2 address.
- rf.Rs1Data  output  data_w  read port 1 data, registered.
- rf.Rs2Data  output  data_w  read port 2 data, registered.
- InitDone  output  1  high once the clear sweep has completed.

Behaviour:
- Reset values: Rs1Data=0, Rs2Data=0, InitDone=0, state=RF_INIT, sweep counter=1. Array contents are not reset.
- FSM states: RF_INIT, RF_RUN.
- RF_INIT:
  - Each cycle writes 0 to entry[counter], then counter+1.
  - When counter==N_REGS-1, the clear is performed and the FSM moves to RF_RUN.
  - InitDone is registered high in the same edge, so it rises on the 15th rising edge after rst_n deasserts (addr_w=4).
  - Interface writes are ignored.
  - Rs1Data/Rs2Data load 0 every cycle.
- RF_RUN:
  - Write: if RdAddr!=0, entry[RdAddr] <= RdData on the rising edge. There is no separate enable; the core drives RdAddr=0 for no-write.
  - Read latency is 1 cycle: RsXData at edge n+1 reflects RsXAddr sampled at edge n.
  - RsXAddr==0 returns 0 regardless of any write.
  - Same-cycle write/read to the same nonzero address is governed by RF_BYPASS_EN.
  - Both read ports may address the same entry, and both return identical data.
- Counter width is addr_w. No wrap occurs, because the transition happens at N_REGS-1.
- rst_n asserted mid-sweep or mid-run: outputs clear immediately (async). The sweep restarts from entry 1 after deassertion and InitDone drops to 0.
- A read and a write to different addresses in the same cycle are independent.
- No X may propagate to Rs1Data/Rs2Data after InitDone=1.

Optional Feature:
RF_BYPASS_EN.
- Defined (write-first): if RdAddr!=0 and RdAddr==RsXAddr in cycle n, RsXData at n+1 = RdData of cycle n.
- Undefined (read-first): RsXData at n+1 = the entry value before the write. The core must then insert a bubble or forward externally.
- x0 reads return 0 in both modes.
- During RF_INIT the bypass is inactive.

Decomposition:
- Package rf_pkg holds:
  - RF_ADDR_W_E=4 and RF_DATA_W=32;
  - typedef enum logic {RF_INIT, RF_RUN} rf_state_e;
  - typedefs rf_addr_t and rf_data_t.
- One natural sub-module: rf_init_seq. It contains the sweep counter and FSM, and outputs clr_we, clr_addr and InitDone.
- rf_drsw_bank muxes clr_we/clr_addr/0 against the interface write port.

Test Plan:
- Release rst_n, idle interface → InitDone=0 for 14 edges, 1 from the 15th. Reading x1..x15 afterwards returns 0x00000000.
- Write x5=0xDEADBEEF, then on the next cycle read Rs1Addr=5, Rs2Addr=5 → both outputs 0xDEADBEEF one cycle later.
- Write x0=0x12345678 while Rs1Addr=0, then read x0 → Rs1Data stays 0 throughout.
- Write x7=0xA5A5A5A5 while Rs1Addr=7 in the same cycle, with x7 previously 0x11111111:
  - RF_BYPASS_EN defined → Rs1Data=0xA5A5A5A5 next cycle.
  - Undefined → 0x11111111, then 0xA5A5A5A5 on a repeat read.
- During sweep (edge 5), drive RdAddr=3, RdData=0xFFFFFFFF → ignored; after InitDone, x3 reads 0.
- After a write of x9=0xCAFEF00D in RF_RUN, pulse rst_n low for 1 cycle → Rs1Data/Rs2Data=0 and InitDone=0 immediately. The sweep repeats for 15 edges, then x9 reads 0.
